mips_fetch_sequencer: RTL and testbench

//  Program-counter and fetch sequencer for the MIPS_CORE datapath. It drives the IMEM byte

---
 rtl/mips_fetch_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_mips_fetch_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// mips_fetch_sequencer
//
// Program counter and fetch sequencer for the MIPS_CORE datapath. It owns the
// IMEM byte address (ReadAddr) and each cycle chooses the next PC from the
// decode/execute feedback (Branch/BranchNe/Zero/Jump/SEImm/JumpValue).
// It also provides run/stall control, self-loop halt detection and a saturating
// retired-instruction counter.
//
// Parameters
//   ADDR_W    IMEM byte-address width (4..28)
//   RESET_PC  PC loaded on reset; bits [1:0] are forced to zero
//   CNT_W     width of the retired-instruction counter
//   HALT_EN   1 = stop in HALT on a self-loop, 0 = keep looping
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset (wins over every other input)
//   run         level: 1 = advance, 0 = hold in IDLE
//   stall       level: 1 = hold the PC this cycle
//   Branch      current instruction is beq/bne
//   BranchNe    with Branch: 1 = bne (taken on !Zero), 0 = beq (taken on Zero)
//   Zero        ALU zero flag of the current instruction
//   Jump        current instruction is j
//   SEImm       sign-extended word offset of the branch
//   JumpValue   j-format target field
//   ReadAddr    current PC (IMEM byte address), bits [1:0] always zero
//   PCPlus4     ReadAddr + 4, modulo 2^ADDR_W (combinational)
//   Redirect    1 for one cycle after a retiring jump or taken branch
//   Halted      1 while in HALT
//   InstrCount  instructions retired since reset, saturating
// -----------------------------------------------------------------------------
module mips_fetch_sequencer #(
  parameter int unsigned ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16,
  parameter bit          HALT_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              stall,
  input  logic              Branch,
  input  logic              BranchNe,
  input  logic              Zero,
  input  logic              Jump,
  input  logic [31:0]       SEImm,
  input  logic [25:0]       JumpValue,
  output logic [ADDR_W-1:0] ReadAddr,
  output logic [ADDR_W-1:0] PCPlus4,
  output logic              Redirect,
  output logic              Halted,
  output logic [CNT_W-1:0]  InstrCount
);

  // Word-aligned reset PC; the low two bits of RESET_PC are dropped.
  localparam logic [ADDR_W-1:0] RESET_PC_AL = {RESET_PC[ADDR_W-1:2], 2'b00};
  localparam logic [ADDR_W-1:0] PC_STEP     = ADDR_W'(3'd4);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1'b1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_redirect;
  logic                r_halted;
  logic [CNT_W-1:0]    r_cnt;

  logic [ADDR_W-1:0]   w_pc_plus4;
  logic [ADDR_W-1:0]   w_br_off;
  logic [ADDR_W-1:0]   w_br_tgt;
  logic [ADDR_W-1:0]   w_jmp_tgt;
  logic                w_br_taken;
  logic [ADDR_W-1:0]   w_next_pc;
  logic                w_take_redirect;
  logic                w_self_loop;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_unused;

  // Only the low address bits of the offset / target fields are in range;
  // the remainder is intentionally discarded.
  assign w_unused = ^{SEImm, JumpValue, RESET_PC};

  assign w_pc_plus4 = r_pc + PC_STEP;
  assign w_br_off   = {SEImm[ADDR_W-3:0], 2'b00};
  assign w_br_tgt   = w_pc_plus4 + w_br_off;
  assign w_jmp_tgt  = {JumpValue[ADDR_W-3:0], 2'b00};
  assign w_br_taken = Branch & (BranchNe ? ~Zero : Zero);

  // Next-PC select: jump has priority over a taken branch, which has
  // priority over the sequential PC.
  always_comb begin
    w_next_pc       = w_pc_plus4;
    w_take_redirect = 1'b0;
    if (Jump) begin
      w_next_pc       = w_jmp_tgt;
      w_take_redirect = 1'b1;
    end else if (w_br_taken) begin
      w_next_pc       = w_br_tgt;
      w_take_redirect = 1'b1;
    end else begin
      w_next_pc       = w_pc_plus4;
      w_take_redirect = 1'b0;
    end
  end

  // Self-loop: the retiring instruction resolves to its own address.
  assign w_self_loop = (w_next_pc == r_pc);

  // Saturating increment of the retired-instruction counter.
  always_comb begin
    w_cnt_next = r_cnt;
    if (&r_cnt) begin
      w_cnt_next = r_cnt;
    end else begin
      w_cnt_next = r_cnt + CNT_ONE;
    end
  end

  // Sequencer FSM with PC, counter and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC_AL;
      r_redirect <= 1'b0;
      r_halted   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      // Redirect is a one-cycle pulse; only a retiring redirect re-arms it.
      r_redirect <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // run=0 takes precedence over stall.
          if (!run) begin
            r_state <= S_IDLE;
          end else if (stall) begin
            // The instruction in flight is not retired; its inputs are
            // re-evaluated once the stall drops.
            r_state <= S_STALL;
          end else begin
            r_cnt      <= w_cnt_next;
            r_redirect <= w_take_redirect;
            if (HALT_EN && w_self_loop) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_pc <= w_next_pc;
            end
          end
        end
        S_STALL: begin
          if (!run) begin
            r_state <= S_IDLE;
          end else if (!stall) begin
            r_state <= S_RUN;
          end
        end
        S_HALT: begin
          // Only reset leaves HALT.
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ReadAddr   = r_pc;
  assign PCPlus4    = w_pc_plus4;
  assign Redirect   = r_redirect;
  assign Halted     = r_halted;
  assign InstrCount = r_cnt;

endmodule

// File: tb/tb_mips_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mips_fetch_sequencer
//
// Directed test of mips_fetch_sequencer. Three instances share all inputs:
//   u_dut   default parameters (ADDR_W=8, CNT_W=16, HALT_EN=1)
//   u_dut_c CNT_W=2 to exercise counter saturation
//   u_dut_h HALT_EN=0 to exercise the non-halting self-loop
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_mips_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic        stall;
  logic        Branch;
  logic        BranchNe;
  logic        Zero;
  logic        Jump;
  logic [31:0] SEImm;
  logic [25:0] JumpValue;

  logic [7:0]  ra_a, p4_a;
  logic        rd_a, hl_a;
  logic [15:0] cnt_a;

  logic [7:0]  ra_c, p4_c;
  logic        rd_c, hl_c;
  logic [1:0]  cnt_c;

  logic [7:0]  ra_h, p4_h;
  logic        rd_h, hl_h;
  logic [15:0] cnt_h;

  int n_cmp;
  int n_bad;

  mips_fetch_sequencer #(.ADDR_W(8), .RESET_PC(32'h0), .CNT_W(16), .HALT_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .run(run), .stall(stall), .Branch(Branch),
    .BranchNe(BranchNe), .Zero(Zero), .Jump(Jump), .SEImm(SEImm),
    .JumpValue(JumpValue), .ReadAddr(ra_a), .PCPlus4(p4_a), .Redirect(rd_a),
    .Halted(hl_a), .InstrCount(cnt_a)
  );

  mips_fetch_sequencer #(.ADDR_W(8), .RESET_PC(32'h0), .CNT_W(2), .HALT_EN(1'b1)) u_dut_c (
    .clk(clk), .reset(reset), .run(run), .stall(stall), .Branch(Branch),
    .BranchNe(BranchNe), .Zero(Zero), .Jump(Jump), .SEImm(SEImm),
    .JumpValue(JumpValue), .ReadAddr(ra_c), .PCPlus4(p4_c), .Redirect(rd_c),
    .Halted(hl_c), .InstrCount(cnt_c)
  );

  mips_fetch_sequencer #(.ADDR_W(8), .RESET_PC(32'h0), .CNT_W(16), .HALT_EN(1'b0)) u_dut_h (
    .clk(clk), .reset(reset), .run(run), .stall(stall), .Branch(Branch),
    .BranchNe(BranchNe), .Zero(Zero), .Jump(Jump), .SEImm(SEImm),
    .JumpValue(JumpValue), .ReadAddr(ra_h), .PCPlus4(p4_h), .Redirect(rd_h),
    .Halted(hl_h), .InstrCount(cnt_h)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always terminates.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, expected finish before it");
    $fatal(1, "watchdog expired");
  end

  // Compare one observed value against its expected value.
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    Branch    = 1'b0;
    BranchNe  = 1'b0;
    Zero      = 1'b0;
    Jump      = 1'b0;
    SEImm     = 32'h0;
    JumpValue = 26'h0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    run   = 1'b0;
    stall = 1'b0;
    clear_ctl();
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check_val("rst_addr",  {24'h0, ra_a}, 32'h0);
    check_val("rst_pc4",   {24'h0, p4_a}, 32'h4);
    check_val("rst_redir", {31'h0, rd_a}, 32'h0);
    check_val("rst_halt",  {31'h0, hl_a}, 32'h0);
    check_val("rst_cnt",   {16'h0, cnt_a}, 32'h0);

    // Test 1: sequential run. First edge only moves IDLE->RUN.
    run = 1'b1;
    tick();
    check_val("seq_addr0", {24'h0, ra_a}, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_val("seq_addr", {24'h0, ra_a}, 32'(i * 4));
      check_val("seq_redir", {31'h0, rd_a}, 32'h0);
    end
    check_val("seq_cnt",   {16'h0, cnt_a}, 32'd5);
    check_val("sat_cnt5",  {30'h0, cnt_c}, 32'd3);

    // Sixth retire: 20 -> 24; 2-bit counter stays saturated.
    tick();
    check_val("seq_addr6", {24'h0, ra_a}, 32'd24);
    check_val("sat_cnt6",  {30'h0, cnt_c}, 32'd3);
    check_val("cnt6",      {16'h0, cnt_a}, 32'd6);

    // Test 3: jump at 24 with JumpValue=0x0100004 -> 0x10.
    Jump      = 1'b1;
    JumpValue = 26'h0100004;
    tick();
    check_val("jmp_addr",  {24'h0, ra_a}, 32'h10);
    check_val("jmp_redir", {31'h0, rd_a}, 32'h1);

    // Test 2a: beq not taken at 16 -> 20, redirect clears.
    clear_ctl();
    Branch = 1'b1;
    SEImm  = 32'hffff_ffff;
    tick();
    check_val("beq_nt_addr",  {24'h0, ra_a}, 32'd20);
    check_val("beq_nt_redir", {31'h0, rd_a}, 32'h0);
    check_val("beq_nt_cnt",   {16'h0, cnt_a}, 32'd8);

    // Test 6b: Jump + taken Branch at 20 (branch target would be 20) -> jump to 16.
    Jump      = 1'b1;
    JumpValue = 26'h4;
    Zero      = 1'b1;
    tick();
    check_val("jb_addr",  {24'h0, ra_a}, 32'd16);
    check_val("jb_redir", {31'h0, rd_a}, 32'h1);
    check_val("jb_halt",  {31'h0, hl_a}, 32'h0);

    // Test 2b: beq taken at 16 with offset -1 -> self-loop, HALT.
    Jump = 1'b0;
    tick();
    check_val("halt_addr", {24'h0, ra_a}, 32'd16);
    check_val("halt_flag", {31'h0, hl_a}, 32'h1);
    check_val("halt_cnt",  {16'h0, cnt_a}, 32'd10);
    check_val("nohalt_addr", {24'h0, ra_h}, 32'd16);
    check_val("nohalt_flag", {31'h0, hl_h}, 32'h0);
    check_val("nohalt_cnt",  {16'h0, cnt_h}, 32'd10);

    // Same inputs again: HALT holds, HALT_EN=0 instance counts another pass.
    tick();
    check_val("halt_cnt2",   {16'h0, cnt_a}, 32'd10);
    check_val("nohalt_cnt2", {16'h0, cnt_h}, 32'd11);
    check_val("nohalt_addr2", {24'h0, ra_h}, 32'd16);

    // HALT ignores run/Jump.
    run       = 1'b0;
    Jump      = 1'b1;
    JumpValue = 26'h0;
    tick();
    run = 1'b1;
    tick();
    tick();
    check_val("halt_hold_addr", {24'h0, ra_a}, 32'd16);
    check_val("halt_hold_flag", {31'h0, hl_a}, 32'h1);
    check_val("halt_hold_cnt",  {16'h0, cnt_a}, 32'd10);
    check_val("halt_hold_redir", {31'h0, rd_a}, 32'h0);

    // Test 5b: reset while halted.
    reset = 1'b1;
    run   = 1'b0;
    clear_ctl();
    tick();
    reset = 1'b0;
    check_val("hrst_addr", {24'h0, ra_a}, 32'h0);
    check_val("hrst_halt", {31'h0, hl_a}, 32'h0);
    check_val("hrst_cnt",  {16'h0, cnt_a}, 32'h0);

    // Test 4a: jump to 0xfc, then sequential wrap to 0.
    run       = 1'b1;
    Jump      = 1'b1;
    JumpValue = 26'h3f;
    tick();
    tick();
    check_val("wrap_pre", {24'h0, ra_a}, 32'hfc);
    clear_ctl();
    #1;
    check_val("wrap_pc4", {24'h0, p4_a}, 32'h0);
    tick();
    check_val("wrap_addr", {24'h0, ra_a}, 32'h0);
    check_val("wrap_cnt",  {16'h0, cnt_a}, 32'd2);

    // Test 4b: bne taken at 0xf8 with SEImm=1 -> 0xfc+4 wraps to 0x00.
    Jump      = 1'b1;
    JumpValue = 26'h3e;
    tick();
    check_val("bne_pre", {24'h0, ra_a}, 32'hf8);
    clear_ctl();
    Branch   = 1'b1;
    BranchNe = 1'b1;
    SEImm    = 32'h1;
    tick();
    check_val("bne_addr",  {24'h0, ra_a}, 32'h0);
    check_val("bne_redir", {31'h0, rd_a}, 32'h1);

    // Test 5a: sequential step, then a stall rising with a jump.
    clear_ctl();
    tick();
    check_val("stl_pre", {24'h0, ra_a}, 32'h4);
    check_val("stl_pre_cnt", {16'h0, cnt_a}, 32'd5);
    stall     = 1'b1;
    Jump      = 1'b1;
    JumpValue = 26'h10;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("stl_addr",  {24'h0, ra_a}, 32'h4);
      check_val("stl_cnt",   {16'h0, cnt_a}, 32'd5);
      check_val("stl_redir", {31'h0, rd_a}, 32'h0);
    end
    stall = 1'b0;
    tick();
    check_val("stl_exit_addr", {24'h0, ra_a}, 32'h4);
    tick();
    check_val("stl_jmp_addr",  {24'h0, ra_a}, 32'h40);
    check_val("stl_jmp_cnt",   {16'h0, cnt_a}, 32'd6);
    check_val("stl_jmp_redir", {31'h0, rd_a}, 32'h1);

    // run=0 together with stall: IDLE, PC holds.
    clear_ctl();
    run   = 1'b0;
    stall = 1'b1;
    tick();
    tick();
    check_val("idle_addr", {24'h0, ra_a}, 32'h40);
    check_val("idle_cnt",  {16'h0, cnt_a}, 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
